lfsr_bist_engine: RTL and testbench



---
 rtl/lfsr_bist_engine.sv | 119 +++++++++++
 tb/tb_lfsr_bist_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_bist_engine.sv
// rtl/lfsr_bist_engine.sv - logic BIST engine: LFSR pattern generator, MISR compactor, shift/capture sequencer
module lfsr_bist_engine #(
    parameter int             N         = 7,
    parameter logic [N-1:0]   TPG_POLY  = 7'h60,
    parameter logic [N-1:0]   SEED      = 7'h01,
    parameter logic [N-1:0]   MISR_POLY = 7'h60,
    parameter int             CHAIN_LEN = 32,
    parameter int             NUM_PAT   = 100,
    parameter logic [N-1:0]   GOLDEN    = 7'h00,
    parameter int             CNT_W     = 16
) (
    input  logic             CK,
    input  logic             reset_n,
    input  logic             start,
    input  logic [N-1:0]     so_in,
    output logic [N-1:0]     tpg_out,
    output logic             scan_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N-1:0]     signature,
    output logic [CNT_W-1:0] pat_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_lfsr;
    logic [N-1:0]     r_misr;
    logic [CNT_W-1:0] r_shift_cnt;
    logic [CNT_W-1:0] r_pat_cnt;
    logic             r_scan_en;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic [N-1:0]     w_lfsr_next;
    logic [N-1:0]     w_misr_next;
    logic             w_last_shift;
    logic             w_more_pat;

    assign w_lfsr_next  = {r_lfsr[N-2:0], ^(r_lfsr & TPG_POLY)};
    assign w_misr_next  = {r_misr[N-2:0], ^(r_misr & MISR_POLY)} ^ so_in;
    assign w_last_shift = (r_shift_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_more_pat   = (r_pat_cnt < CNT_W'(NUM_PAT));

    always_ff @(posedge CK) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_lfsr      <= SEED;
            r_misr      <= '0;
            r_shift_cnt <= '0;
            r_pat_cnt   <= '0;
            r_scan_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_lfsr      <= SEED;
                        r_misr      <= '0;
                        r_shift_cnt <= '0;
                        r_pat_cnt   <= '0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_scan_en   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_lfsr <= w_lfsr_next;
                    // The first unload carries only the initial chain contents, not a response.
                    if (r_pat_cnt != '0) begin
                        r_misr <= w_misr_next;
                    end
                    if (w_last_shift) begin
                        r_shift_cnt <= '0;
                        r_scan_en   <= 1'b0;
                        r_state     <= w_more_pat ? S_CAPTURE : S_COMPARE;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_pat_cnt <= r_pat_cnt + 1'b1;
                    r_scan_en <= 1'b1;
                    r_state   <= S_SHIFT;
                end
                S_COMPARE: begin
                    r_pass  <= (r_misr == GOLDEN);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tpg_out   = r_lfsr;
    assign scan_en   = r_scan_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_misr;
    assign pat_cnt   = r_pat_cnt;

endmodule

// File: tb/tb_lfsr_bist_engine.sv
// tb/tb_lfsr_bist_engine.sv - directed self-checking bench for lfsr_bist_engine
module tb_lfsr_bist_engine;

    logic        CK = 1'b0;
    logic        reset_n;
    logic        d_start, s_start;
    logic [6:0]  d_so, s_so;

    logic [6:0]  d_tpg, d_sig, s_tpg, s_sig;
    logic        d_scan_en, d_busy, d_done, d_pass;
    logic        s_scan_en, s_busy, s_done, s_pass;
    logic [15:0] d_pat, s_pat;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] tpg_tbl [0:7] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

    always #5 CK = ~CK;

    lfsr_bist_engine u_dflt (
        .CK        (CK),
        .reset_n   (reset_n),
        .start     (d_start),
        .so_in     (d_so),
        .tpg_out   (d_tpg),
        .scan_en   (d_scan_en),
        .busy      (d_busy),
        .done      (d_done),
        .pass      (d_pass),
        .signature (d_sig),
        .pat_cnt   (d_pat)
    );

    lfsr_bist_engine #(
        .CHAIN_LEN (2),
        .NUM_PAT   (1),
        .GOLDEN    (7'h01)
    ) u_small (
        .CK        (CK),
        .reset_n   (reset_n),
        .start     (s_start),
        .so_in     (s_so),
        .tpg_out   (s_tpg),
        .scan_en   (s_scan_en),
        .busy      (s_busy),
        .done      (s_done),
        .pass      (s_pass),
        .signature (s_sig),
        .pat_cnt   (s_pat)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // One full run of the small instance: start edge is edge 1, done must appear after edge 7.
    task automatic run_small(input bit flip, input bit poke, input logic [6:0] exp_sig, input bit exp_pass);
        s_so    = 7'h7F;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check_eq("small_e1_scan_en", 32'(s_scan_en), 32'd1);
        check_eq("small_e1_busy", 32'(s_busy), 32'd1);
        check_eq("small_e1_tpg", 32'(s_tpg), 32'h01);
        check_eq("small_e1_done", 32'(s_done), 32'd0);
        for (int e = 2; e <= 7; e++) begin
            s_so    = (flip && e == 6) ? 7'h77 : 7'h7F;
            s_start = poke && (e == 2 || e == 4);
            tick();
            s_start = 1'b0;
            if (e <= 5)
                check_eq("small_scan_en", 32'(s_scan_en), (e != 3) ? 32'd1 : 32'd0);
            if (e == 3)
                check_eq("misr_gated_first_phase", 32'(s_sig), 32'h00);
            if (e == 6) begin
                check_eq("compare_done", 32'(s_done), 32'd0);
                check_eq("compare_busy", 32'(s_busy), 32'd1);
            end
        end
        check_eq("small_done", 32'(s_done), 32'd1);
        check_eq("small_busy_at_done", 32'(s_busy), 32'd0);
        check_eq("small_signature", 32'(s_sig), 32'(exp_sig));
        check_eq("small_pass", 32'(s_pass), 32'(exp_pass));
        check_eq("small_pat_cnt", 32'(s_pat), 32'd1);
        repeat (3) tick();
        check_eq("pass_held", 32'(s_pass), 32'(exp_pass));
        check_eq("done_held", 32'(s_done), 32'd1);
        check_eq("sig_held", 32'(s_sig), 32'(exp_sig));
    endtask

    initial begin
        int  e;
        int  steps;
        bit  en;
        bit  saw_zero;

        reset_n = 1'b0;
        d_start = 1'b0;
        s_start = 1'b0;
        d_so    = '0;
        s_so    = '0;
        tick();
        tick();
        reset_n = 1'b1;
        check_eq("rst_tpg", 32'(d_tpg), 32'h01);
        check_eq("rst_sig", 32'(d_sig), 32'h00);
        check_eq("rst_scan_en", 32'(d_scan_en), 32'd0);
        check_eq("rst_busy", 32'(d_busy), 32'd0);
        check_eq("rst_done", 32'(d_done), 32'd0);
        check_eq("rst_pass", 32'(d_pass), 32'd0);

        // Reset held together with start must keep the engine idle.
        reset_n = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        reset_n = 1'b1;
        tick();
        check_eq("reset_beats_start_busy", 32'(s_busy), 32'd0);
        check_eq("reset_beats_start_scan", 32'(s_scan_en), 32'd0);

        run_small(1'b0, 1'b0, 7'h01, 1'b1);
        run_small(1'b1, 1'b1, 7'h09, 1'b0);

        // Restart directly from DONE.
        s_so    = '0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check_eq("restart_done", 32'(s_done), 32'd0);
        check_eq("restart_busy", 32'(s_busy), 32'd1);
        check_eq("restart_tpg", 32'(s_tpg), 32'h01);
        check_eq("restart_sig", 32'(s_sig), 32'h00);
        check_eq("restart_pass", 32'(s_pass), 32'd0);
        tick();
        check_eq("restart_tpg_next", 32'(s_tpg), 32'h02);

        // Full default run: LFSR sequence, period and overall timing.
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        e = 1;
        check_eq("tpg_seq_0", 32'(d_tpg), 32'h01);
        steps    = 0;
        saw_zero = 1'b0;
        while (steps < 127 && e < 1000) begin
            en = d_scan_en;
            tick();
            e++;
            if (en) begin
                steps++;
                if (d_tpg == 7'h00)
                    saw_zero = 1'b1;
                if (steps <= 7)
                    check_eq($sformatf("tpg_seq_%0d", steps), 32'(d_tpg), 32'(tpg_tbl[steps]));
            end
        end
        check_eq("tpg_steps_reached", 32'(steps), 32'd127);
        check_eq("tpg_never_zero", 32'(saw_zero), 32'd0);
        check_eq("tpg_period_127", 32'(d_tpg), 32'h01);
        while (!d_done && e < 5000) begin
            tick();
            e++;
        end
        check_eq("dflt_done_edge", 32'(e), 32'd3334);
        check_eq("dflt_pass", 32'(d_pass), 32'd1);
        check_eq("dflt_sig", 32'(d_sig), 32'h00);
        check_eq("dflt_pat_cnt", 32'(d_pat), 32'd100);
        check_eq("dflt_busy", 32'(d_busy), 32'd0);

        // Reset mid-SHIFT at pat_cnt=5.
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        e = 0;
        while (!(d_pat == 16'd5 && d_scan_en) && e < 1000) begin
            tick();
            e++;
        end
        check_eq("midrun_reached_pat5", 32'(d_pat), 32'd5);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check_eq("midrst_tpg", 32'(d_tpg), 32'h01);
        check_eq("midrst_sig", 32'(d_sig), 32'h00);
        check_eq("midrst_scan_en", 32'(d_scan_en), 32'd0);
        check_eq("midrst_busy", 32'(d_busy), 32'd0);
        check_eq("midrst_done", 32'(d_done), 32'd0);
        check_eq("midrst_pat_cnt", 32'(d_pat), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
